fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//  Writer side of the systolic FIR coefficient inputs. Accepts coefficient packets on an AXI4-Stream
//  style slave, fills a shadow bank, then commits all taps atomically to the coeffN inputs of the filter.
//  Sits in the filter clock domain. Its flat coeff_o bus fans out to the per-tap coefficient ports.
// PARAMETERS
//  NTAPS       5        taps per packet / coefficient outputs (2..16)
//  COEFF_BITS  18       coefficient width (DSP B-port width)
//  USE_CE      "FALSE"  "TRUE": commit waits for ce_i=1; "FALSE": ce_i ignored (treated as 1)
// PORTS
//  clk_i            in   1                   filter clock
//  rst_i            in   1                   synchronous, active-high reset
//  ce_i             in   1                   filter clock enable (commit qualifier)
//  s_coeff_tdata    in   COEFF_BITS          coefficient, two's complement, tap 0 first
//  s_coeff_tvalid   in   1                   beat valid
//  s_coeff_tready   out  1                   beat accepted when tvalid&&tready
//  s_coeff_tlast    in   1                   marks final beat of packet
//  coeff_o          out  NTAPS*COEFF_BITS    active bank; tap k at [k*COEFF_BITS +: COEFF_BITS]
//  update_o         out  1                   one-cycle pulse: coeff_o changed this cycle
//  err_o            out  1                   sticky framing error, cleared only by rst_i
// BEHAVIOUR
//  Reset: coeff_o=0, update_o=0, err_o=0, s_coeff_tready=1, shadow=0, tap index=0, state LOAD.
//  States: LOAD (tready=1), DRAIN (tready=1, beats discarded), COMMIT (tready=0).
//  LOAD, accepted beat at index i: shadow[i]<=tdata.
//   i<NTAPS-1, tlast=0  -> i<=i+1.
//   i<NTAPS-1, tlast=1  -> short packet: err_o<=1, shadow contents ignored, i<=0, stay LOAD.
//   i=NTAPS-1, tlast=1  -> i<=0, go COMMIT.
//   i=NTAPS-1, tlast=0  -> long packet: err_o<=1, go DRAIN.
//  DRAIN: discard beats until an accepted beat has tlast=1, then i<=0, go LOAD. No commit.
//  COMMIT: on first edge with ce=1, coeff_o<=shadow (all taps on the same edge).
//   On that edge update_o<=1 for exactly one cycle and the state goes to LOAD.
//   Otherwise hold COMMIT with tready=0.
//  Latency with ce=1: last beat accepted at edge E, coeff_o and update_o valid after edge E+1.
//  The earliest next beat is accepted at edge E+2.
//  coeff_o never shows a partial bank. Only the COMMIT edge writes it.
//  A failed packet leaves coeff_o unchanged.
//  No arithmetic. Data passes bit-exact. Packets may have idle (tvalid=0) gaps.
//  rst_i mid-packet or in COMMIT: the pending bank is lost and all reset values apply on the next edge.
//  rst_i has priority over every other event.
// CONFIGURATION
//  FIR_COEFF_READBACK_EN defined: adds rd_addr_i (in, $clog2(NTAPS)) and rd_data_o (out, COEFF_BITS).
//   rd_data_o is a registered read of active tap rd_addr_i with 1-cycle latency, reset 0.
//   rd_addr_i>=NTAPS returns 0.
//  FIR_COEFF_READBACK_EN undefined: the ports and read mux are absent. All other behaviour is identical.
// STRUCTURE
//  Package fir_coeff_pkg: coeff_t (signed [COEFF_BITS-1:0]) and state enum {LOAD, DRAIN, COMMIT}.
//  The package also holds the default constants COEFF_BITS_DEF=18 and NTAPS_DEF=5.
//  No sub-module. The shadow and active banks are plain register arrays in this module.
// TESTING
//  1 Reset, then packet 1,2,3,4,5 (tlast on 5), ce=1 -> coeff_o={5,4,3,2,1}, one update_o pulse after edge E+1.
//  2 Packet -1,0x1FFFF,-0x20000,7,0 -> coeff_o exact bit patterns 3FFFF,1FFFF,20000,7,0. err_o=0.
//  3 3-beat packet with tlast on beat 3 -> err_o=1, coeff_o unchanged, no update_o.
//    Next good packet then commits normally.
//  4 7-beat packet (tlast on beat 7) -> err_o=1, beats 6-7 drained, no update_o.
//    A following 5-beat packet commits.
//  5 USE_CE="TRUE", ce_i low 4 cycles after last beat -> tready=0 for those cycles.
//    Commit and update_o occur on the first edge with ce_i=1.
//  6 rst_i after beat 3 of a packet -> coeff_o=0, err_o=0, index 0.
//    The next 5-beat packet commits correctly. With FIR_COEFF_READBACK_EN, rd_addr_i=2 returns tap 2.

Source files
------------

// File: rtl/fir_coeff_pkg.sv
// Shared types and default sizes for the FIR coefficient loader.
package fir_coeff_pkg;

    localparam int COEFF_BITS_DEF = 18;
    localparam int NTAPS_DEF      = 5;

    typedef logic signed [COEFF_BITS_DEF-1:0] coeff_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Coefficient stream bundle (AXI4-Stream subset: tdata/tvalid/tready/tlast).
interface fir_coeff_loader_if #(
    parameter int COEFF_BITS = fir_coeff_pkg::COEFF_BITS_DEF
);
    logic [COEFF_BITS-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fir_coeff_loader.sv
// Fills a shadow coefficient bank from a stream and commits it atomically to the filter taps.
// Optional FIR_COEFF_READBACK_EN adds a registered read port on the active bank.
module fir_coeff_loader
    import fir_coeff_pkg::*;
#(
    parameter int    NTAPS      = NTAPS_DEF,
    parameter int    COEFF_BITS = COEFF_BITS_DEF,
    parameter string USE_CE     = "FALSE"
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ce_i,
    fir_coeff_loader_if.slave           s_coeff,
    output logic [NTAPS*COEFF_BITS-1:0] coeff_o,
    output logic                        update_o,
    output logic                        err_o
`ifdef FIR_COEFF_READBACK_EN
    ,
    input  logic [$clog2(NTAPS)-1:0]    rd_addr_i,
    output logic [COEFF_BITS-1:0]       rd_data_o
`endif
);

    localparam int               IDX_W = $clog2(NTAPS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NTAPS - 1);
    localparam bit               CE_EN = (USE_CE == "TRUE");

    typedef logic signed [COEFF_BITS-1:0] tap_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    tap_t             shadow_q [NTAPS];
    tap_t             shadow_d [NTAPS];
    tap_t             coeff_q  [NTAPS];
    tap_t             coeff_d  [NTAPS];
    logic             update_q, update_d;
    logic             err_q, err_d;
    logic             tready_q, tready_d;
    logic             ce_eff;
    logic             accept;

    assign ce_eff = CE_EN ? ce_i : 1'b1;
    assign accept = s_coeff.tvalid && tready_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        coeff_d  = coeff_q;
        update_d = 1'b0;
        err_d    = err_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    shadow_d[idx_q] = tap_t'(s_coeff.tdata);
                    if (idx_q == LAST) begin
                        if (s_coeff.tlast) begin
                            idx_d   = '0;
                            state_d = COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (s_coeff.tlast) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept && s_coeff.tlast) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            COMMIT: begin
                // The whole bank moves on one edge so the filter never sees a mix of old and new taps.
                if (ce_eff) begin
                    coeff_d  = shadow_q;
                    update_d = 1'b1;
                    state_d  = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        tready_d = (state_d != COMMIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= LOAD;
            idx_q    <= '0;
            shadow_q <= '{default: '0};
            coeff_q  <= '{default: '0};
            update_q <= 1'b0;
            err_q    <= 1'b0;
            tready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            coeff_q  <= coeff_d;
            update_q <= update_d;
            err_q    <= err_d;
            tready_q <= tready_d;
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_flat
        assign coeff_o[k*COEFF_BITS +: COEFF_BITS] = coeff_q[k];
    end

    assign update_o       = update_q;
    assign err_o          = err_q;
    assign s_coeff.tready = tready_q;

`ifdef FIR_COEFF_READBACK_EN
    logic [COEFF_BITS-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        if (int'(rd_addr_i) < NTAPS) rd_data_d = coeff_q[rd_addr_i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader (default and USE_CE="TRUE" instances).
module tb_fir_coeff_loader;
    import fir_coeff_pkg::*;

    localparam int NT = 5;
    localparam int CB = 18;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic ce0   = 1'b0;
    logic ce1   = 1'b1;
    logic [NT*CB-1:0] coeff0, coeff1;
    logic update0, update1, err0, err1;
    int tests = 0;
    int fails = 0;
    int upd_cnt0 = 0;
    int upd_cnt1 = 0;

    always #5 clk_i = ~clk_i;

    fir_coeff_loader_if #(.COEFF_BITS(CB)) s0 ();
    fir_coeff_loader_if #(.COEFF_BITS(CB)) s1 ();

`ifdef FIR_COEFF_READBACK_EN
    logic [$clog2(NT)-1:0] rd_addr0 = '0;
    logic [$clog2(NT)-1:0] rd_addr1 = '0;
    logic [CB-1:0]         rd_data0, rd_data1;
`endif

    fir_coeff_loader #(.NTAPS(NT), .COEFF_BITS(CB), .USE_CE("FALSE")) dut0 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ce_i     (ce0),
        .s_coeff  (s0),
        .coeff_o  (coeff0),
        .update_o (update0),
        .err_o    (err0)
`ifdef FIR_COEFF_READBACK_EN
        ,
        .rd_addr_i(rd_addr0),
        .rd_data_o(rd_data0)
`endif
    );

    fir_coeff_loader #(.NTAPS(NT), .COEFF_BITS(CB), .USE_CE("TRUE")) dut1 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ce_i     (ce1),
        .s_coeff  (s1),
        .coeff_o  (coeff1),
        .update_o (update1),
        .err_o    (err1)
`ifdef FIR_COEFF_READBACK_EN
        ,
        .rd_addr_i(rd_addr1),
        .rd_data_o(rd_data1)
`endif
    );

    always @(negedge clk_i) begin
        if (update0 === 1'b1) upd_cnt0++;
        if (update1 === 1'b1) upd_cnt1++;
    end

    function automatic logic [NT*CB-1:0] pack5(input logic [CB-1:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat0(input logic [CB-1:0] d, input logic last);
        s0.tdata  = d;
        s0.tlast  = last;
        s0.tvalid = 1'b1;
        @(posedge clk_i);
        #1;
        s0.tvalid = 1'b0;
        s0.tlast  = 1'b0;
    endtask

    task automatic beat1(input logic [CB-1:0] d, input logic last);
        s1.tdata  = d;
        s1.tlast  = last;
        s1.tvalid = 1'b1;
        @(posedge clk_i);
        #1;
        s1.tvalid = 1'b0;
        s1.tlast  = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
    endtask

    logic [NT*CB-1:0] bank;

    initial begin
        s0.tdata = '0; s0.tvalid = 1'b0; s0.tlast = 1'b0;
        s1.tdata = '0; s1.tvalid = 1'b0; s1.tlast = 1'b0;

        // Reset state
        do_reset();
        chk("rst_coeff", coeff0, '0);
        chk("rst_update", update0, 1'b0);
        chk("rst_err", err0, 1'b0);
        chk("rst_tready", s0.tready, 1'b1);

        // Packet 1..5 with ce0 held low: USE_CE="FALSE" must ignore it
        for (int i = 1; i <= 5; i++) beat0(CB'(i), i == 5);
        chk("t1_commit_pending_tready", s0.tready, 1'b0);
        chk("t1_no_early_update", update0, 1'b0);
        chk("t1_no_early_coeff", coeff0, '0);
        cyc(1);
        bank = pack5(18'd1, 18'd2, 18'd3, 18'd4, 18'd5);
        chk("t1_coeff", coeff0, bank);
        chk("t1_update_pulse", update0, 1'b1);
        chk("t1_tready_back", s0.tready, 1'b1);
        cyc(1);
        chk("t1_update_drop", update0, 1'b0);
        chk("t1_upd_count", upd_cnt0, 1);

        // Extreme bit patterns with idle gaps between beats
        beat0(18'h3FFFF, 1'b0);
        cyc(2);
        beat0(18'h1FFFF, 1'b0);
        beat0(18'h20000, 1'b0);
        cyc(1);
        beat0(18'h00007, 1'b0);
        beat0(18'h00000, 1'b1);
        cyc(1);
        bank = pack5(18'h3FFFF, 18'h1FFFF, 18'h20000, 18'h00007, 18'h00000);
        chk("t2_coeff", coeff0, bank);
        chk("t2_err", err0, 1'b0);
        cyc(1);
        chk("t2_upd_count", upd_cnt0, 2);

        // Short packet: error, bank kept, no update
        beat0(18'd9, 1'b0);
        beat0(18'd9, 1'b0);
        beat0(18'd9, 1'b1);
        chk("t3_err", err0, 1'b1);
        chk("t3_tready", s0.tready, 1'b1);
        cyc(3);
        chk("t3_coeff_kept", coeff0, bank);
        chk("t3_upd_count", upd_cnt0, 2);
        for (int i = 10; i <= 14; i++) beat0(CB'(i), i == 14);
        cyc(1);
        bank = pack5(18'd10, 18'd11, 18'd12, 18'd13, 18'd14);
        chk("t3_recover_coeff", coeff0, bank);
        chk("t3_err_sticky", err0, 1'b1);
        cyc(1);
        chk("t3_upd_count2", upd_cnt0, 3);

        // Reset clears the sticky error
        do_reset();
        chk("rst2_err", err0, 1'b0);
        chk("rst2_coeff", coeff0, '0);

        // Long packet: error, extra beats drained, no update
        for (int i = 20; i <= 24; i++) beat0(CB'(i), 1'b0);
        chk("t4_err", err0, 1'b1);
        chk("t4_drain_tready", s0.tready, 1'b1);
        beat0(18'd25, 1'b0);
        beat0(18'd26, 1'b1);
        cyc(3);
        chk("t4_coeff_kept", coeff0, '0);
        chk("t4_upd_count", upd_cnt0, 3);
        for (int i = 30; i <= 34; i++) beat0(CB'(i), i == 34);
        cyc(1);
        bank = pack5(18'd30, 18'd31, 18'd32, 18'd33, 18'd34);
        chk("t4_recover_coeff", coeff0, bank);
        chk("t4_recover_update", update0, 1'b1);
        cyc(1);

        // Reset mid-packet drops the pending bank and the index
        beat0(18'd1, 1'b0);
        beat0(18'd2, 1'b0);
        beat0(18'd3, 1'b0);
        rst_i = 1'b1;
        cyc(1);
        rst_i = 1'b0;
        chk("t6_coeff", coeff0, '0);
        chk("t6_err", err0, 1'b0);
        chk("t6_update", update0, 1'b0);
        chk("t6_tready", s0.tready, 1'b1);
        for (int i = 40; i <= 44; i++) beat0(CB'(i), i == 44);
        cyc(1);
        bank = pack5(18'd40, 18'd41, 18'd42, 18'd43, 18'd44);
        chk("t6_coeff_after", coeff0, bank);
        chk("t6_err_after", err0, 1'b0);
        cyc(1);
        chk("t6_upd_count", upd_cnt0, 5);
`ifdef FIR_COEFF_READBACK_EN
        rd_addr0 = 3'd2;
        cyc(1);
        chk("rb_tap2", rd_data0, 18'd42);
        rd_addr0 = 3'd4;
        cyc(1);
        chk("rb_tap4", rd_data0, 18'd44);
        rd_addr0 = 3'd5;
        cyc(1);
        chk("rb_oob", rd_data0, 18'd0);
`endif

        // USE_CE="TRUE": commit stalls while ce is low
        ce1 = 1'b0;
        for (int i = 50; i <= 54; i++) beat1(CB'(i), i == 54);
        for (int k = 0; k < 4; k++) begin
            chk("t5_stall_tready", s1.tready, 1'b0);
            chk("t5_stall_coeff", coeff1, '0);
            cyc(1);
        end
        chk("t5_no_update", upd_cnt1, 0);
        ce1 = 1'b1;
        cyc(1);
        bank = pack5(18'd50, 18'd51, 18'd52, 18'd53, 18'd54);
        chk("t5_coeff", coeff1, bank);
        chk("t5_update", update1, 1'b1);
        chk("t5_tready", s1.tready, 1'b1);
        cyc(1);
        chk("t5_upd_count", upd_cnt1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
